// File: rtl/umi_demux_pkg.sv
// Shared sizing helpers for the buffered UMI demultiplexer and its per-port FIFO.
package umi_demux_pkg;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned payload_width(input int unsigned cw,
                                                input int unsigned aw,
                                                input int unsigned dw);
    return cw + 2 * aw + dw;
  endfunction

endpackage

// File: rtl/umi_demux_buf.sv
// Single-clock FIFO of DEPTH entries with wrap-bit pointers; head is presented combinationally.
module umi_demux_buf
  import umi_demux_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = 416
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [PW-1:0]                   din,
  input  logic                            pop,
  output logic [PW-1:0]                   dout,
  output logic                            full,
  output logic                            empty,
  output logic [occ_width(DEPTH)-1:0]     occupancy
);

  localparam int unsigned PTRW = ptr_width(DEPTH);
  localparam int unsigned ADRW = PTRW - 1;
  localparam int unsigned OW   = occ_width(DEPTH);

  logic [PW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] count;
  logic            push_en;
  logic            pop_en;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  // Same slot, opposite lap: the writer has wrapped once more than the reader.
  assign full    = (wr_ptr[PTRW-1] != rd_ptr[PTRW-1]) &&
                   (wr_ptr[ADRW-1:0] == rd_ptr[ADRW-1:0]);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign occupancy = OW'(count);
  assign dout      = mem[rd_ptr[ADRW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[ADRW-1:0]] <= din;
  end

endmodule

// File: rtl/umi_demux_buffered.sv
// Address-decoded UMI demux: each output has its own FIFO; unmapped indices are dropped and counted.
module umi_demux_buffered
  import umi_demux_pkg::*;
#(
  parameter int unsigned M      = 4,
  parameter int unsigned DW     = 256,
  parameter int unsigned CW     = 32,
  parameter int unsigned AW     = 64,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned SELLSB = 40,
  parameter int unsigned SELW   = $clog2(M)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              err_clear,
  input  logic                              umi_in_valid,
  input  logic [CW-1:0]                     umi_in_cmd,
  input  logic [AW-1:0]                     umi_in_dstaddr,
  input  logic [AW-1:0]                     umi_in_srcaddr,
  input  logic [DW-1:0]                     umi_in_data,
  output logic                              umi_in_ready,
  output logic [M-1:0]                      umi_out_valid,
  output logic [M*CW-1:0]                   umi_out_cmd,
  output logic [M*AW-1:0]                   umi_out_dstaddr,
  output logic [M*AW-1:0]                   umi_out_srcaddr,
  output logic [M*DW-1:0]                   umi_out_data,
  input  logic [M-1:0]                      umi_out_ready,
  output logic [M*occ_width(DEPTH)-1:0]     occupancy,
  output logic [15:0]                       drop_count,
  output logic                              err_sticky
);

  localparam int unsigned PW = payload_width(CW, AW, DW);
  localparam int unsigned OW = occ_width(DEPTH);

  logic [SELW-1:0] idx;
  logic            hit;
  logic            drop;
  logic [M-1:0]    full;
  logic [M-1:0]    empty;
  logic [M-1:0]    push;
  logic [PW-1:0]   in_payload;

  assign idx        = umi_in_dstaddr[SELLSB +: SELW];
  assign hit        = 32'(idx) < M;
  assign drop       = umi_in_valid && !hit;
  assign in_payload = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};

  // Unmapped indices leave ready at 1 so the transaction is swallowed.
  always_comb begin
    umi_in_ready = 1'b1;
    push         = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (32'(idx) == i) begin
        umi_in_ready = !full[i];
        push[i]      = umi_in_valid && !full[i];
      end
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_port
    logic [PW-1:0] head;

    umi_demux_buf #(
      .DEPTH (DEPTH),
      .PW    (PW)
    ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (push[g]),
      .din       (in_payload),
      .pop       (umi_out_ready[g]),
      .dout      (head),
      .full      (full[g]),
      .empty     (empty[g]),
      .occupancy (occupancy[g*OW +: OW])
    );

    assign umi_out_valid[g] = !empty[g];
    assign {umi_out_cmd[g*CW +: CW], umi_out_dstaddr[g*AW +: AW],
            umi_out_srcaddr[g*AW +: AW], umi_out_data[g*DW +: DW]} = head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      err_sticky <= 1'b0;
    end else if (err_clear) begin
      drop_count <= '0;
      err_sticky <= 1'b0;
    end else if (drop) begin
      err_sticky <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule
